multicycle_datapath: RTL

Responder side of the multicycle CPU control interface: receives the per-cycle control word from the controller and executes it. Holds PC, IR, MDR, A, B, ALUOut and a 32x32 register file. Returns opCode and the ALU zero flag to the controller, and drives a single-port instruction/data memory with asynchronous read.

---
 rtl/multicycle_datapath_if.sv | 34 +++
 rtl/multicycle_datapath.sv | 106 ++++++++++
 2 files changed

// File: rtl/multicycle_datapath_if.sv
// Control/status and memory bus between the multicycle controller and its datapath.
// The master side issues the control word and answers memory reads; the slave is the datapath.
interface multicycle_datapath_if;
  logic        ALUOp;
  logic        PCWriteCond;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        IorD;
  logic        MemWrite;
  logic        MemtoReg;
  logic        IRWrite;
  logic        ALUSrcA;
  logic        RegWrite;
  logic        RegDst;
  logic [5:0]  opCode;
  logic        zero;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (
    output ALUOp, PCWriteCond, ALUSrcB, PCSource, PCWrite, IorD, MemWrite,
           MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, mem_rdata,
    input  opCode, zero, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  ALUOp, PCWriteCond, ALUSrcB, PCSource, PCWrite, IorD, MemWrite,
           MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, mem_rdata,
    output opCode, zero, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle CPU datapath: PC, IR, MDR, A, B, ALUOut and a 32x32 register file,
// executing one controller-issued control word per clock edge.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_datapath_if.slave  bus
);

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  logic        [31:0] pc_q;
  logic        [31:0] ir_q;
  logic        [31:0] mdr_q;
  logic        [31:0] a_q;
  logic        [31:0] b_q;
  logic        [31:0] alu_out_q;
  logic        [31:0] rf [32];

  logic signed [31:0] imm_ext;
  logic signed [31:0] alu_a;
  logic signed [31:0] alu_b;
  logic        [31:0] alu_res;
  logic        [31:0] pc_next;
  logic               pc_we;
  logic        [4:0]  wr_addr;
  logic        [31:0] wr_data;

  // Add/sub wrap silently; slt compares as two's complement.
  function automatic logic [31:0] alu_calc(input logic              force_add,
                                           input logic [5:0]        funct,
                                           input logic signed [31:0] x,
                                           input logic signed [31:0] y);
    if (force_add) return x + y;
    case (funct)
      F_ADD:   return x + y;
      F_SUB:   return x - y;
      F_AND:   return x & y;
      F_OR:    return x | y;
      F_NOR:   return ~(x | y);
      F_SLT:   return {31'b0, (x < y)};
      default: return x + y;
    endcase
  endfunction

  always_comb begin
    imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};
    alu_a   = bus.ALUSrcA ? a_q : pc_q;
    case (bus.ALUSrcB)
      2'b00:   alu_b = b_q;
      2'b01:   alu_b = 32'sd4;
      2'b10:   alu_b = imm_ext;
      default: alu_b = imm_ext <<< 2;
    endcase
    alu_res = alu_calc(bus.ALUOp, ir_q[5:0], alu_a, alu_b);
  end

  // PCSource=11 is a hold selection, so it masks the write enable entirely.
  always_comb begin
    pc_we   = (bus.PCWrite | (bus.PCWriteCond & bus.zero)) & (bus.PCSource != 2'b11);
    pc_next = pc_q;
    case (bus.PCSource)
      2'b00:   pc_next = alu_res;
      2'b01:   pc_next = alu_out_q;
      2'b10:   pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: pc_next = pc_q;
    endcase
  end

  assign wr_addr = bus.RegDst ? ir_q[15:11] : ir_q[20:16];
  assign wr_data = bus.MemtoReg ? mdr_q : alu_out_q;

  assign bus.zero      = (alu_res == '0);
  assign bus.opCode    = ir_q[31:26];
  assign bus.mem_addr  = bus.IorD ? alu_out_q : pc_q;
  assign bus.mem_wdata = b_q;
  assign bus.mem_we    = bus.MemWrite & ~reset;

  // Every architectural register updates on this edge from pre-edge values; no read bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      a_q       <= rf[ir_q[25:21]];
      b_q       <= rf[ir_q[20:16]];
      mdr_q     <= bus.mem_rdata;
      alu_out_q <= alu_res;
      if (bus.IRWrite) ir_q <= bus.mem_rdata;
      if (pc_we) pc_q <= pc_next;
      if (bus.RegWrite && (wr_addr != 5'd0)) rf[wr_addr] <= wr_data;
    end
  end

endmodule
